// File: rtl/placar_sessao.sv
// placar_sessao: session scoreboard for the blackjack FSM.
// Counts each round's win/lose/tie exactly once, keeps saturating
// tallies for the display path and blinks an LED for the last result.
//
// state | meaning
// ARMED | waiting for this round's result (armado = 1)
// DONE  | result counted, further rises ignored until rodada_reset
module placar_sessao #(
    parameter logic [26:0] BLINK_LIMIT = 27'd25000000,
    parameter logic [6:0]  CNT_MAX     = 7'd99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rodada_reset,
    input  logic       win,
    input  logic       lose,
    input  logic       tie,
    output logic [6:0] vitorias,
    output logic [6:0] derrotas,
    output logic [6:0] empates,
    output logic [6:0] rodadas,
    output logic [1:0] ultimo_resultado,
    output logic       resultado_valido,
    output logic       led_blink,
    output logic       erro
);

    typedef enum logic {
        DONE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t      state;
    logic        win_q, lose_q, tie_q;
    logic [26:0] blink_cnt;
    logic        win_r, lose_r, tie_r;

    // Rising edges of the FSM status levels against last cycle's sample
    assign win_r  = win  & ~win_q;
    assign lose_r = lose & ~lose_q;
    assign tie_r  = tie  & ~tie_q;

    // Scoreboard FSM: edge history, round arming, tallies and blink timer
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ARMED;
            win_q            <= 1'b0;
            lose_q           <= 1'b0;
            tie_q            <= 1'b0;
            vitorias         <= '0;
            derrotas         <= '0;
            empates          <= '0;
            rodadas          <= '0;
            ultimo_resultado <= 2'b00;
            resultado_valido <= 1'b0;
            led_blink        <= 1'b0;
            erro             <= 1'b0;
            blink_cnt        <= '0;
        end else begin
            // History always advances so a rise swallowed by rodada_reset
            // is never seen again.
            win_q  <= win;
            lose_q <= lose;
            tie_q  <= tie;
            if (rodada_reset) begin
                state            <= ARMED;
                ultimo_resultado <= 2'b00;
                resultado_valido <= 1'b0;
                led_blink        <= 1'b0;
                erro             <= 1'b0;
                blink_cnt        <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        blink_cnt <= '0;
                        case ({win_r, lose_r, tie_r})
                            3'b000: ;
                            3'b100, 3'b010, 3'b001: begin
                                if (win_r && vitorias < CNT_MAX)
                                    vitorias <= vitorias + 7'd1;
                                if (lose_r && derrotas < CNT_MAX)
                                    derrotas <= derrotas + 7'd1;
                                if (tie_r && empates < CNT_MAX)
                                    empates <= empates + 7'd1;
                                if (rodadas < CNT_MAX)
                                    rodadas <= rodadas + 7'd1;
                                ultimo_resultado <= win_r  ? 2'b01 :
                                                    lose_r ? 2'b10 : 2'b11;
                                resultado_valido <= 1'b1;
                                led_blink        <= 1'b1;
                                state            <= DONE;
                            end
                            default: erro <= 1'b1;
                        endcase
                    end
                    DONE: begin
                        // resultado_valido is always high here
                        if (blink_cnt == BLINK_LIMIT - 27'd1) begin
                            blink_cnt <= '0;
                            led_blink <= ~led_blink;
                        end else begin
                            blink_cnt <= blink_cnt + 27'd1;
                        end
                    end
                    default: state <= ARMED;
                endcase
            end
        end
    end

endmodule
